alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_defs_pkg.sv | 33 +++
 rtl/mips_regfile.sv | 40 ++++
 rtl/alu_issue_ctrl.sv | 137 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_defs_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_defs (package)
//  Brief    : Shared R-type opcode/funct codes, issue FSM state encoding and
//             legality helper used by the issue controller and the ALU.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_defs;

    localparam logic [5:0] c_opc_rtype = 6'd0;

    localparam logic [5:0] c_fn_add = 6'd27;
    localparam logic [5:0] c_fn_sub = 6'd28;
    localparam logic [5:0] c_fn_srl = 6'd29;
    localparam logic [5:0] c_fn_sll = 6'd30;
    localparam logic [5:0] c_fn_xor = 6'd31;
    localparam logic [5:0] c_fn_and = 6'd32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    // Only R-type words with one of the six supported funct codes execute.
    function automatic logic is_legal(input logic [5:0] opcode, input logic [5:0] funct);
        return (opcode == c_opc_rtype) &&
               ((funct == c_fn_add) || (funct == c_fn_sub) || (funct == c_fn_srl) ||
                (funct == c_fn_sll) || (funct == c_fn_xor) || (funct == c_fn_and));
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : mips_regfile
//  Brief    : 32x32 register file, two async read ports plus a debug read
//             port, one synchronous write port; r0 is hard-wired to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module mips_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  i_ra_addr,
    output logic [31:0] o_ra_data,
    input  logic [4:0]  i_rb_addr,
    output logic [31:0] o_rb_data,
    input  logic [4:0]  i_dbg_addr,
    output logic [31:0] o_dbg_data,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata
);

    logic [31:0] r_mem [0:31];

    // Storage: cleared on reset, writes to r0 dropped so entry 0 stays zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr != 5'd0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_ra_data  = (i_ra_addr  == 5'd0) ? 32'd0 : r_mem[i_ra_addr];
    assign o_rb_data  = (i_rb_addr  == 5'd0) ? 32'd0 : r_mem[i_rb_addr];
    assign o_dbg_data = (i_dbg_addr == 5'd0) ? 32'd0 : r_mem[i_dbg_addr];

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_ctrl
//  Brief    : Issues R-type instructions to an external combinational ALU,
//             writes results back into a local register file and keeps
//             sticky zero/carry flags. One instruction every three cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl
    import alu_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    input  logic        ld_en,
    input  logic [4:0]  ld_addr,
    input  logic [31:0] ld_data,
    output logic [31:0] alu_src1,
    output logic [31:0] alu_src2,
    output logic [5:0]  alu_funct,
    output logic [4:0]  alu_shamt,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_carry,
    output logic        done,
    output logic        illegal,
    output logic        zero_flag,
    output logic        carry_flag,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_rd;
    logic        r_legal;

    logic [5:0]  w_opcode;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_shamt;
    logic [5:0]  w_funct;
    logic [31:0] w_rs_data;
    logic [31:0] w_rt_data;
    logic        w_accept;
    logic        w_we;
    logic [4:0]  w_waddr;
    logic [31:0] w_wdata;

    assign w_opcode = instr[31:26];
    assign w_rs     = instr[25:21];
    assign w_rt     = instr[20:16];
    assign w_rd     = instr[15:11];
    assign w_shamt  = instr[10:6];
    assign w_funct  = instr[5:0];

    // A host preload in IDLE takes priority over a pending instruction.
    assign instr_ready = (r_state == ST_IDLE) && !ld_en && !rst;
    assign w_accept    = (r_state == ST_IDLE) && instr_valid && !ld_en;

    // The single write port is shared: preload in IDLE, writeback in EXEC.
    assign w_we    = ((r_state == ST_IDLE) && ld_en) || ((r_state == ST_EXEC) && r_legal);
    assign w_waddr = (r_state == ST_EXEC) ? r_rd : ld_addr;
    assign w_wdata = (r_state == ST_EXEC) ? alu_result : ld_data;

    assign done    = (r_state == ST_WB);
    assign illegal = (r_state == ST_WB) && !r_legal;

    mips_regfile u_regfile (
        .clk        (clk),
        .rst        (rst),
        .i_ra_addr  (w_rs),
        .o_ra_data  (w_rs_data),
        .i_rb_addr  (w_rt),
        .o_rb_data  (w_rt_data),
        .i_dbg_addr (dbg_addr),
        .o_dbg_data (dbg_data),
        .i_we       (w_we),
        .i_waddr    (w_waddr),
        .i_wdata    (w_wdata)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: IDLE waits for an accept, EXEC and WB each last one cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_EXEC;
            ST_EXEC: w_state_nxt = ST_WB;
            ST_WB:   w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture on accept; values hold until the next accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_src1  <= '0;
            alu_src2  <= '0;
            alu_funct <= '0;
            alu_shamt <= '0;
            r_rd      <= '0;
            r_legal   <= 1'b0;
        end else if (w_accept) begin
            alu_src1  <= w_rs_data;
            alu_src2  <= w_rt_data;
            alu_funct <= w_funct;
            alu_shamt <= w_shamt;
            r_rd      <= w_rd;
            r_legal   <= is_legal(w_opcode, w_funct);
        end
    end

    // Sticky flags, refreshed only when a legal op leaves EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
        end else if ((r_state == ST_EXEC) && r_legal) begin
            zero_flag  <= alu_zero;
            carry_flag <= alu_carry;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_issue_ctrl
//  Brief    : Self-checking bench for alu_issue_ctrl with a behavioural ALU,
//             a register/flag reference model, directed vectors and random ops.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        ld_en;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [5:0]  alu_funct;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_carry;
    logic        done;
    logic        illegal;
    logic        zero_flag;
    logic        carry_flag;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .alu_src1    (alu_src1),
        .alu_src2    (alu_src2),
        .alu_funct   (alu_funct),
        .alu_shamt   (alu_shamt),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .alu_carry   (alu_carry),
        .done        (done),
        .illegal     (illegal),
        .zero_flag   (zero_flag),
        .carry_flag  (carry_flag),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // Arithmetic meaning of each funct: {carry, result}. SUB carry = borrow.
    function automatic logic [32:0] alu_ref(input logic [5:0] fn, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
        case (fn)
            6'd27:   return {1'b0, a} + {1'b0, b};
            6'd28:   return {(a < b), a - b};
            6'd29:   return {1'b0, a >> sh};
            6'd30:   return {1'b0, a << sh};
            6'd31:   return {1'b0, a ^ b};
            6'd32:   return {1'b0, a & b};
            default: return 33'd0;
        endcase
    endfunction

    // External ALU seen by the DUT.
    logic [32:0] alu_out;
    always_comb alu_out = alu_ref(alu_funct, alu_src1, alu_src2, alu_shamt);
    assign alu_result = alu_out[31:0];
    assign alu_carry  = alu_out[32];
    assign alu_zero   = (alu_out[31:0] == 32'd0);

    // Reference state.
    logic [31:0] m_reg [32];
    logic        m_z;
    logic        m_c;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dbg_rd(input logic [4:0] a, output logic [31:0] d);
        dbg_addr = a;
        #1;
        d = dbg_data;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
        m_z = 1'b0;
        m_c = 1'b0;
    endtask

    task automatic do_load(input logic [4:0] a, input logic [31:0] d);
        tick();
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
        if (a != 5'd0) m_reg[a] = d;
    endtask

    // One full instruction; noise drives ld_en/instr_valid during EXEC/WB.
    task automatic do_issue(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                            input bit noise);
        logic [31:0] a, b, d;
        logic [32:0] r;
        logic        leg;
        tick();
        instr = {op, rs, rt, rd, sh, fn};
        instr_valid = 1'b1;
        #1 chk("ready_before_accept", instr_ready, 1);
        a   = m_reg[rs];
        b   = m_reg[rt];
        leg = (op == 6'd0) && (fn >= 6'd27) && (fn <= 6'd32);
        r   = alu_ref(fn, a, b, sh);
        tick();
        instr_valid = 1'b0;
        if (noise) begin
            instr_valid = 1'b1; instr = $urandom;
            ld_en = 1'b1; ld_addr = 5'($urandom_range(1, 31)); ld_data = $urandom;
        end
        chk("src1", alu_src1, a);
        chk("src2", alu_src2, b);
        chk("funct", {26'd0, alu_funct}, {26'd0, fn});
        chk("shamt", {27'd0, alu_shamt}, {27'd0, sh});
        chk("done_in_exec", done, 0);
        chk("ready_in_exec", instr_ready, 0);
        tick();
        chk("done_in_wb", done, 1);
        chk("illegal_in_wb", illegal, !leg);
        if (leg && rd != 5'd0) m_reg[rd] = r[31:0];
        if (leg) begin
            m_z = (r[31:0] == 32'd0);
            m_c = r[32];
        end
        chk("zero_flag", zero_flag, m_z);
        chk("carry_flag", carry_flag, m_c);
        dbg_rd(rd, d);
        chk("rd_value", d, m_reg[rd]);
        tick();
        instr_valid = 1'b0;
        ld_en = 1'b0;
        #1;
        chk("done_after_wb", done, 0);
        chk("ready_after_wb", instr_ready, 1);
    endtask

    typedef struct {
        bit          ld;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  fn;
        logic [31:0] val;
        logic        z, c;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit ld, logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                logic [4:0] rd, logic [4:0] sh, logic [5:0] fn,
                                logic [31:0] val, logic z, logic c);
        vec_t v;
        v.ld = ld; v.op = op; v.rs = rs; v.rt = rt; v.rd = rd; v.sh = sh; v.fn = fn;
        v.val = val; v.z = z; v.c = c;
        return v;
    endfunction

    initial begin
        logic [31:0] d;
        bit          all_zero;

        rst = 1'b1; instr_valid = 1'b0; instr = '0; ld_en = 1'b0;
        ld_addr = '0; ld_data = '0; dbg_addr = '0;
        model_clear();

        // Directed vectors: loads use rd/val as address/data.
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 32'd5, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 2, 0, 0, 32'd3, 0, 0));
        tbl.push_back(mk(0, 0, 1, 2, 3, 0, 27, 32'd8, 0, 0));
        tbl.push_back(mk(0, 0, 3, 3, 3, 0, 27, 32'd16, 0, 0));
        tbl.push_back(mk(0, 0, 2, 1, 4, 0, 28, 32'hFFFF_FFFE, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 5, 0, 28, 32'd0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 6, 0, 0, 32'hFFFF_FFFF, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 7, 0, 0, 32'd1, 0, 0));
        tbl.push_back(mk(0, 0, 6, 7, 8, 0, 27, 32'd0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 2, 12, 0, 10, 32'd0, 1, 1));
        tbl.push_back(mk(0, 8, 1, 2, 13, 0, 27, 32'd0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 4, 30, 32'd0, 0, 0));
        tbl.push_back(mk(0, 0, 6, 7, 14, 0, 32, 32'd1, 0, 0));

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("ready_in_reset", instr_ready, 0);
        rst = 1'b0;
        #1;
        chk("rst_done", done, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_zero_flag", zero_flag, 0);
        chk("rst_carry_flag", carry_flag, 0);
        chk("rst_src1", alu_src1, 0);
        chk("rst_funct", {26'd0, alu_funct}, 0);
        chk("rst_ready", instr_ready, 1);

        // Directed table.
        foreach (tbl[i]) begin
            if (tbl[i].ld) begin
                do_load(tbl[i].rd, tbl[i].val);
                dbg_rd(tbl[i].rd, d);
                chk("tbl_load", d, tbl[i].val);
            end else begin
                do_issue(tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].sh, tbl[i].fn, 0);
                dbg_rd(tbl[i].rd, d);
                chk("tbl_rd", d, tbl[i].val);
                chk("tbl_zero", zero_flag, tbl[i].z);
                chk("tbl_carry", carry_flag, tbl[i].c);
            end
        end

        // Load and instruction in the same cycle: load wins, issue waits.
        tick();
        ld_en = 1'b1; ld_addr = 5'd10; ld_data = 32'h1234_0000;
        instr_valid = 1'b1; instr = {6'd0, 5'd10, 5'd10, 5'd11, 5'd0, 6'd27};
        #1 chk("ld_vs_instr_ready", instr_ready, 0);
        tick();
        ld_en = 1'b0;
        m_reg[10] = 32'h1234_0000;
        #1 chk("ready_after_ld", instr_ready, 1);
        dbg_rd(5'd10, d);
        chk("ld_applied", d, 32'h1234_0000);
        tick();
        instr_valid = 1'b0;
        chk("deferred_src1", alu_src1, 32'h1234_0000);
        tick();
        chk("deferred_done", done, 1);
        dbg_rd(5'd11, d);
        chk("deferred_result", d, 32'h2468_0000);
        m_reg[11] = 32'h2468_0000;
        m_z = 1'b0; m_c = 1'b0;
        tick();

        // Random stimulus against the model.
        for (int i = 0; i < 8; i++) do_load(5'($urandom_range(1, 31)), $urandom);
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_load(5'($urandom), $urandom);
            end else begin
                do_issue(($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'd0,
                         5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                         6'($urandom_range(25, 34)), bit'($urandom_range(0, 1)));
            end
        end
        for (int i = 0; i < 32; i++) begin
            dbg_rd(5'(i), d);
            chk($sformatf("final_r%0d", i), d, m_reg[i]);
        end

        // Reset while an ADD rd=9 is in EXEC.
        do_load(5'd1, 32'd5);
        do_load(5'd2, 32'd3);
        tick();
        instr_valid = 1'b1; instr = {6'd0, 5'd1, 5'd2, 5'd9, 5'd0, 6'd27};
        tick();
        instr_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_exec_ready", instr_ready, 0);
        chk("rst_exec_done", done, 0);
        chk("rst_exec_src1", alu_src1, 0);
        tick();
        rst = 1'b0;
        model_clear();
        #1 chk("rst_exec_done_n1", done, 0);
        chk("rst_exec_idle", instr_ready, 1);
        tick();
        chk("rst_exec_done_n2", done, 0);
        chk("rst_exec_flags", {30'd0, zero_flag, carry_flag}, 0);
        all_zero = 1'b1;
        for (int i = 0; i < 32; i++) begin
            dbg_rd(5'(i), d);
            if (d !== 32'd0) all_zero = 1'b0;
        end
        chk("rst_exec_regs_zero", all_zero, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
